wash_panel_ctrl: RTL

Front-panel controller: the user-side end of the washing-machine FSM interface. It debounces the select/start buttons and drives program_selection and a one-cycle start pulse into the FSM. It consumes the FSM's timer_display, program_done, soap_warning and lockDoor outputs to drive BCD digits, LEDs and a buzzer. It sits between the physical panel and the FSM, on the same clock.

---
 rtl/wash_fsm_if.sv | 14 +
 rtl/wash_panel_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wash_fsm_if.sv
// Panel <-> washing-machine FSM link: program/start toward the FSM, status back.
interface wash_fsm_if;
  logic [2:0] program_selection;
  logic       start;
  logic [7:0] timer_display;
  logic       program_done;
  logic       soap_warning;
  logic       lockDoor;

  modport master (output program_selection, start,
                  input  timer_display, program_done, soap_warning, lockDoor);
  modport slave  (input  program_selection, start,
                  output timer_display, program_done, soap_warning, lockDoor);
endinterface

// File: rtl/wash_panel_ctrl.sv
// Front-panel controller: debounced buttons, program select/start toward the
// FSM, BCD timer digits, LEDs and buzzer driven from FSM status.
module wash_btn_db #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic raw,
  output logic evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1, s2, db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; db <= 1'b0; db_q <= 1'b0; cnt <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      if (clr || s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end

  assign evt = db & ~db_q;
endmodule

module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BUZZ_CYCLES     = 20,
  parameter int BLINK_CYCLES    = 8,
  parameter int START_TIMEOUT   = 50,
  parameter int NUM_PROGRAMS    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  input  logic             btn_select,
  input  logic             btn_start,
  input  logic             doorclosed,
  wash_fsm_if.master       fsm,
  output logic [3:0]       digit_tens,
  output logic [3:0]       digit_ones,
  output logic [3:0]       prog_leds,
  output logic             soap_led,
  output logic             lock_led,
  output logic             buzzer,
  output logic [1:0]       panel_state
);
  localparam int NUM_BTN = 2;
  localparam int BZW     = $clog2(BUZZ_CYCLES + 1);
  localparam int TOW     = $clog2(START_TIMEOUT + 1);
  localparam int BLW     = $clog2(2 * BLINK_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, DONE = 2'd2} state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_evt;
  assign btn_raw = {btn_start, btn_select};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    wash_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .clr(~power), .raw(btn_raw[g]), .evt(btn_evt[g])
    );
  end

  state_t           state, state_n;
  logic [2:0]       sel, sel_n;
  logic             start_q, start_n;
  logic [BZW-1:0]   buzz_cnt, buzz_n;
  logic [TOW-1:0]   to_cnt, to_n;
  logic             lock_seen, seen_n;
  logic             pd_q;
  logic             sel_evt, start_evt, pd_rise;

  // Events are dropped while unpowered.
  assign sel_evt   = power & btn_evt[0];
  assign start_evt = power & btn_evt[1];
  assign pd_rise   = fsm.program_done & ~pd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; sel <= '0; start_q <= 1'b0; buzz_cnt <= '0;
      to_cnt <= '0; lock_seen <= 1'b0; pd_q <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      start_q   <= start_n;
      buzz_cnt  <= buzz_n;
      to_cnt    <= to_n;
      lock_seen <= seen_n;
      pd_q      <= fsm.program_done;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    start_n = 1'b0;
    buzz_n  = (buzz_cnt != '0) ? buzz_cnt - BZW'(1) : '0;
    to_n    = to_cnt;
    seen_n  = lock_seen;
    if (!power) begin
      state_n = IDLE;
      buzz_n  = '0;
      to_n    = '0;
      seen_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_evt) begin
            if (doorclosed) begin
              start_n = 1'b1;
              state_n = RUNNING;
              to_n    = '0;
              seen_n  = 1'b0;
            end else buzz_n = BZW'(BUZZ_CYCLES);
          end else if (sel_evt) begin
            sel_n = (sel == 3'(NUM_PROGRAMS - 1)) ? '0 : sel + 3'd1;
          end
        end
        RUNNING: begin
          if (pd_rise) begin
            state_n = DONE;
            buzz_n  = BZW'(BUZZ_CYCLES);
          end else if (fsm.lockDoor) seen_n = 1'b1;
          else if (!lock_seen) begin
            if (to_cnt == TOW'(START_TIMEOUT - 1)) state_n = IDLE;
            else to_n = to_cnt + TOW'(1);
          end
        end
        DONE: begin
          // Last buzzer cycle or a button press both end the DONE display.
          if (sel_evt || start_evt || buzz_cnt <= BZW'(1)) begin
            state_n = IDLE;
            buzz_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [3:0] bcd_t, bcd_o;

  always_comb begin
    if (fsm.timer_display > 8'd99) begin
      bcd_t = 4'd9;
      bcd_o = 4'd9;
    end else begin
      bcd_t = 4'(fsm.timer_display / 8'd10);
      bcd_o = 4'(fsm.timer_display % 8'd10);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_tens <= '0; digit_ones <= '0; prog_leds <= 4'b0001; lock_led <= 1'b0;
    end else if (!power) begin
      digit_tens <= '0; digit_ones <= '0; prog_leds <= '0; lock_led <= 1'b0;
    end else begin
      digit_tens <= bcd_t;
      digit_ones <= bcd_o;
      prog_leds  <= 4'b0001 << sel;
      lock_led   <= fsm.lockDoor;
    end
  end

  logic [BLW-1:0] blink_cnt;

  // Blink phase restarts high whenever the warning re-asserts.
  always_ff @(posedge clk) begin
    if (rst || !power || !fsm.soap_warning) begin
      soap_led  <= 1'b0;
      blink_cnt <= '0;
    end else begin
      soap_led  <= (blink_cnt < BLW'(BLINK_CYCLES));
      blink_cnt <= (blink_cnt == BLW'(2 * BLINK_CYCLES - 1)) ? '0 : blink_cnt + BLW'(1);
    end
  end

  assign fsm.program_selection = sel;
  assign fsm.start             = start_q;
  assign buzzer                = (buzz_cnt != '0);
  assign panel_state           = state;
endmodule
